// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl: time-multiplexed AES S-box engine. LANES S-box lookups are
// shared between a 128-bit SubBytes requester (state port) and a 32-bit SubWord
// requester (word port). One request is serviced at a time, LANES bytes per cycle.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   st_valid/st_ready   state request handshake
//   st_in, st_out       state operand, registered SubBytes result
//   st_done             one-cycle pulse when st_out has been fully updated
//   wd_valid/wd_ready   word request handshake
//   wd_in, wd_out       word operand, registered SubWord result
//   wd_done             one-cycle pulse when wd_out has been fully updated
//   busy                a request is being sequenced through the lanes
module sbox_share_ctrl #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_valid,
   output logic         st_ready,
   input  logic [127:0] st_in,
   output logic [127:0] st_out,
   output logic         st_done,
   input  logic         wd_valid,
   output logic         wd_ready,
   input  logic [31:0]  wd_in,
   output logic [31:0]  wd_out,
   output logic         wd_done,
   output logic         busy
);

   typedef enum logic [1:0] {StIdle, StRunSt, StRunWd} state_e;

   localparam logic [3:0] StLast = 4'(16 / LANES - 1);
   localparam logic [3:0] WdLast = 4'(4 / LANES - 1);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   state_e       state_q;
   logic [3:0]   cnt_q;
   logic         last_wd_q;  // 1 when the word port won the most recent grant
   logic [127:0] op_q;

   logic [3:0]   lane_idx [LANES];
   logic [7:0]   lane_in  [LANES];
   logic [7:0]   lane_out [LANES];

   // Round-robin: on a tie the port that was not granted last wins.
   assign st_ready = (state_q == StIdle) & ~rst & ~(wd_valid & ~last_wd_q);
   assign wd_ready = (state_q == StIdle) & ~rst & ~(st_valid & last_wd_q);
   assign busy     = (state_q != StIdle);

   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         lane_idx[j] = cnt_q * 4'(LANES) + 4'(j);
         lane_in[j]  = (state_q == StIdle) ? 8'h00 : op_q[8*lane_idx[j] +: 8];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_out[g] = SBOX[lane_in[g]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         last_wd_q <= 1'b0;
         op_q      <= '0;
         st_out    <= '0;
         wd_out    <= '0;
         st_done   <= 1'b0;
         wd_done   <= 1'b0;
      end else begin
         st_done <= 1'b0;
         wd_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (st_valid && st_ready) begin
                  op_q      <= st_in;
                  cnt_q     <= 4'd0;
                  last_wd_q <= 1'b0;
                  state_q   <= StRunSt;
               end else if (wd_valid && wd_ready) begin
                  op_q      <= {96'd0, wd_in};
                  cnt_q     <= 4'd0;
                  last_wd_q <= 1'b1;
                  state_q   <= StRunWd;
               end
            end
            StRunSt: begin
               for (int j = 0; j < LANES; j++) begin
                  st_out[8*lane_idx[j] +: 8] <= lane_out[j];
               end
               if (cnt_q == StLast) begin
                  cnt_q   <= 4'd0;
                  st_done <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            StRunWd: begin
               for (int j = 0; j < LANES; j++) begin
                  wd_out[8*lane_idx[j][1:0] +: 8] <= lane_out[j];
               end
               if (cnt_q == WdLast) begin
                  cnt_q   <= 4'd0;
                  wd_done <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: a LANES=4 instance carries the bulk of the
// vectors, a LANES=1 instance checks the serialised latency.
module tb_sbox_share_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;

   logic         st_valid = 1'b0, wd_valid = 1'b0;
   logic [127:0] st_in = '0;
   logic [31:0]  wd_in = '0;
   logic         st_ready, wd_ready, st_done, wd_done, busy;
   logic [127:0] st_out;
   logic [31:0]  wd_out;

   logic         st_valid1 = 1'b0, wd_valid1 = 1'b0;
   logic [127:0] st_in1 = '0;
   logic [31:0]  wd_in1 = '0;
   logic         st_ready1, wd_ready1, st_done1, wd_done1, busy1;
   logic [127:0] st_out1;
   logic [31:0]  wd_out1;

   int nvec = 0;
   int nfail = 0;

   localparam logic [127:0] S_ZERO  = 128'h0;
   localparam logic [127:0] S_63    = 128'h63636363_63636363_63636363_63636363;
   localparam logic [127:0] S_SEQ0  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
   localparam logic [127:0] S_SEQ0X = 128'h76abd7fe_2b670130_c56f6bf2_7b777c63;
   localparam logic [127:0] S_SEQ1  = 128'h1f1e1d1c_1b1a1918_17161514_13121110;
   localparam logic [127:0] S_SEQ1X = 128'hc072a49c_afa2d4ad_f04759fa_7dc982ca;
   localparam logic [127:0] S_53    = 128'h53535353_53535353_53535353_53535353;
   localparam logic [127:0] S_ED    = 128'hedededed_edededed_edededed_edededed;
   localparam logic [127:0] S_FF    = 128'hffffffff_ffffffff_ffffffff_ffffffff;
   localparam logic [127:0] S_16    = 128'h16161616_16161616_16161616_16161616;

   always #5 clk = ~clk;

   sbox_share_ctrl #(.LANES(4)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in), .st_out(st_out),
      .st_done(st_done),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_in(wd_in), .wd_out(wd_out),
      .wd_done(wd_done), .busy(busy)
   );

   sbox_share_ctrl #(.LANES(1)) dut1 (
      .clk(clk), .rst(rst),
      .st_valid(st_valid1), .st_ready(st_ready1), .st_in(st_in1), .st_out(st_out1),
      .st_done(st_done1),
      .wd_valid(wd_valid1), .wd_ready(wd_ready1), .wd_in(wd_in1), .wd_out(wd_out1),
      .wd_done(wd_done1), .busy(busy1)
   );

   typedef struct {
      bit           is_wd;
      logic [127:0] din;
      logic [127:0] dexp;
      int           lat;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Waits for the selected done pulse on the LANES=4 instance; returns cycles
   // since the accept edge (40 if it never came) and whether busy stayed high.
   task automatic wait_done(input bit is_wd, output int cyc, output bit busy_ok);
      bit seen = 1'b0;
      cyc = 0;
      busy_ok = 1'b1;
      while (!seen && cyc < 40) begin
         tick();
         cyc++;
         if (is_wd ? wd_done : st_done) seen = 1'b1;
         else if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic run_req(input bit is_wd, input logic [127:0] din,
                          input logic [127:0] dexp, input int lat, input string nm);
      logic [127:0] other;
      int           cyc;
      bit           busy_ok;
      other = is_wd ? st_out : {96'd0, wd_out};
      if (is_wd) begin
         wd_in = din[31:0];
         wd_valid = 1'b1;
      end else begin
         st_in = din;
         st_valid = 1'b1;
      end
      #1;
      check({nm, " ready"}, is_wd ? wd_ready : st_ready, 1);
      tick();
      st_valid = 1'b0;
      wd_valid = 1'b0;
      wait_done(is_wd, cyc, busy_ok);
      check({nm, " latency"}, cyc, lat);
      check({nm, " result"}, is_wd ? {96'd0, wd_out} : st_out, dexp);
      check({nm, " idle port result held"}, is_wd ? st_out : {96'd0, wd_out}, other);
      check({nm, " busy/other done/busy during run"},
            {busy, (is_wd ? st_done : wd_done), ~busy_ok}, 0);
   endtask

   task automatic run1(input bit is_wd, input logic [127:0] din,
                       input logic [127:0] dexp, input int lat, input string nm);
      int cyc = 0;
      bit seen = 1'b0;
      if (is_wd) begin
         wd_in1 = din[31:0];
         wd_valid1 = 1'b1;
      end else begin
         st_in1 = din;
         st_valid1 = 1'b1;
      end
      tick();
      st_valid1 = 1'b0;
      wd_valid1 = 1'b0;
      while (!seen && cyc < 40) begin
         tick();
         cyc++;
         if (is_wd ? wd_done1 : st_done1) seen = 1'b1;
      end
      check({nm, " latency"}, cyc, lat);
      check({nm, " result"}, is_wd ? {96'd0, wd_out1} : st_out1, dexp);
   endtask

   initial begin
      int  cyc;
      bit  bok;
      bit  spur;

      vecs[0] = '{1'b0, S_ZERO, S_63, 4};
      vecs[1] = '{1'b0, S_SEQ0, S_SEQ0X, 4};
      vecs[2] = '{1'b1, 128'h00010203, 128'h637c777b, 1};
      vecs[3] = '{1'b0, S_SEQ1, S_SEQ1X, 4};
      vecs[4] = '{1'b1, 128'h53535353, 128'hedededed, 1};
      vecs[5] = '{1'b0, S_FF, S_16, 4};
      vecs[6] = '{1'b1, 128'hffffffff, 128'h16161616, 1};

      // Reset state; both valids high to show ready is gated by rst.
      st_valid = 1'b1;
      wd_valid = 1'b1;
      #2;
      check("reset ready", {st_ready, wd_ready}, 0);
      check("reset outputs", {st_out, wd_out, st_done, wd_done, busy}, 0);
      tick();
      st_valid = 1'b0;
      wd_valid = 1'b0;
      rst = 1'b0;
      #1;

      for (int i = 0; i < 7; i++) begin
         run_req(vecs[i].is_wd, vecs[i].din, vecs[i].dexp, vecs[i].lat,
                 $sformatf("vec%0d", i));
      end

      // Back-to-back state requests: second is presented in the first's done cycle.
      run_req(1'b0, S_ZERO, S_63, 4, "b2b first");
      run_req(1'b0, S_53, S_ED, 4, "b2b second");

      // Simultaneous requests after reset: word wins first, then alternation.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      st_in = S_SEQ0;
      wd_in = 32'h00010203;
      st_valid = 1'b1;
      wd_valid = 1'b1;
      #1;
      check("tie1 grant", {st_ready, wd_ready}, 2'b01);
      tick();
      wd_valid = 1'b0;
      tick();
      check("tie1 wd_done/st_ready", {wd_done, st_ready}, 2'b11);
      check("tie1 wd_out", wd_out, 32'h637c777b);
      tick();
      st_valid = 1'b0;
      wait_done(1'b0, cyc, bok);
      check("tie1 st latency", cyc, 4);
      check("tie1 st_out", st_out, S_SEQ0X);
      st_in = S_ZERO;
      wd_in = 32'hffffffff;
      st_valid = 1'b1;
      wd_valid = 1'b1;
      #1;
      check("tie2 grant", {st_ready, wd_ready}, 2'b01);
      tick();
      tick();
      check("tie2 done cycle grant", {wd_done, st_ready, wd_ready}, 3'b110);
      tick();
      st_valid = 1'b0;
      wd_valid = 1'b0;
      wait_done(1'b0, cyc, bok);
      check("tie2 st latency", cyc, 4);
      check("tie2 results", {st_out, wd_out}, {S_63, 32'h16161616});

      // Reset two cycles into a state operation.
      st_in = S_SEQ1;
      st_valid = 1'b1;
      tick();
      st_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("midop reset outputs", {st_out, wd_out, busy, st_ready, wd_ready}, 0);
      spur = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (st_done || busy) spur = 1'b1;
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (st_done || busy) spur = 1'b1;
      end
      check("midop no done after reset", spur, 0);
      run_req(1'b0, S_SEQ0, S_SEQ0X, 4, "post reset");

      // Single-lane instance.
      run1(1'b0, S_SEQ0, S_SEQ0X, 16, "lanes1 state");
      run1(1'b1, 128'h00010203, 128'h637c777b, 4, "lanes1 word");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
